// File: rtl/scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl
//
// This is the scan scheduler for the multiplexed 7-segment display of the
// numeric clock. It splits the system clock into per-digit slots of PRESCALE
// cycles and steps through the enabled digits only. Each slot starts with BLANK
// dark cycles for anti-ghosting, and the lit part of the slot fills the rest.
// On each index load, a one-cycle fetch strobe tells the datapath to load the
// digit that select_afisare now points at.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   enable         scanning enabled; low keeps the display dark (IDLE)
//   digit_mask     bit i = 1 shows digit i, 0 skips it
//   blink_sel      index of the digit to blink (SCAN_BLINK_EN only)
//   blink_on       blink request (SCAN_BLINK_EN only)
//   select_afisare current digit index for the datapath mux
//   fetch          one-cycle pulse after each index load
//   anode_n        active-low anode enables, at most one bit low
//
// Optional feature macro: SCAN_BLINK_EN
//   When this macro is defined, a rotation counter toggles a blink phase every
//   BLINK_SCANS full rotations. During phase 1, the blink_sel digit stays dark
//   for as long as blink_on is high.
// -----------------------------------------------------------------------------
module scan_display_ctrl #(
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLANK       = 16,
    parameter int unsigned BLINK_SCANS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIGITS-1:0] digit_mask,
    input  logic [2:0]        blink_sel,
    input  logic              blink_on,
    output logic [2:0]        select_afisare,
    output logic              fetch,
    output logic [DIGITS-1:0] anode_n
);

    localparam int unsigned   CW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      nxt_sel;
    logic [DIGITS-1:0] lit_value;
    logic            blink_dark;

    // Return the lowest set index. The caller guarantees that m is not zero.
    function automatic logic [2:0] lowest_index(input logic [DIGITS-1:0] m);
        logic [2:0] res;
        res = '0;
        for (int unsigned i = DIGITS; i > 0; i--) begin
            if (m[i-1]) res = 3'(i - 1);
        end
        return res;
    endfunction

    // Return the next set index strictly after cur, wrapping around.
    // If cur is the only set bit, the search lands back on cur.
    function automatic logic [2:0] next_index(input logic [2:0] cur,
                                              input logic [DIGITS-1:0] m);
        logic [2:0]  res;
        logic        found;
        int unsigned j;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= DIGITS; k++) begin
            j = int'(cur) + k;
            if (j >= DIGITS) j = j - DIGITS;
            if (!found && m[j]) begin
                res   = 3'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [DIGITS-1:0] lit_anodes(input logic [2:0] s,
                                                     input logic [DIGITS-1:0] m,
                                                     input logic dark);
        logic [DIGITS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            oh[i] = (s == 3'(i));
        end
        return dark ? '1 : ~(oh & m);
    endfunction

`ifdef SCAN_BLINK_EN
    localparam int unsigned   RW       = $clog2(BLINK_SCANS + 1);
    localparam logic [RW-1:0] ROT_LAST = RW'(BLINK_SCANS - 1);

    logic [RW-1:0] rot_cnt;
    logic          blink_phase;

    always_comb begin
        blink_dark = blink_on && blink_phase && (select_afisare == blink_sel);
    end
`else
    logic unused_blink;
    assign unused_blink = ^{blink_sel, blink_on};

    always_comb begin
        blink_dark = 1'b0;
    end
`endif

    always_comb begin
        nxt_sel   = next_index(select_afisare, digit_mask);
        lit_value = lit_anodes(select_afisare, digit_mask, blink_dark);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            select_afisare <= '0;
            fetch          <= 1'b0;
            anode_n        <= '1;
            cnt            <= '0;
`ifdef SCAN_BLINK_EN
            rot_cnt        <= '0;
            blink_phase    <= 1'b0;
`endif
        end else if (!enable || digit_mask == '0) begin
            // Override from any state. The index is held so that the datapath
            // keeps its last selection.
            state   <= S_IDLE;
            fetch   <= 1'b0;
            anode_n <= '1;
            cnt     <= '0;
        end else begin
            fetch <= 1'b0;
            case (state)
                S_IDLE: begin
                    select_afisare <= lowest_index(digit_mask);
                    fetch          <= 1'b1;
                    anode_n        <= '1;
                    cnt            <= '0;
                    state          <= S_BLANK;
                end
                S_BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state   <= S_SHOW;
                        anode_n <= lit_value;
                    end else begin
                        anode_n <= '1;
                    end
                end
                S_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt            <= '0;
                        select_afisare <= nxt_sel;
                        fetch          <= 1'b1;
                        anode_n        <= '1;
                        state          <= S_BLANK;
`ifdef SCAN_BLINK_EN
                        // A wrap (including a single-digit reselect) ends one rotation.
                        if (nxt_sel <= select_afisare) begin
                            if (rot_cnt == ROT_LAST) begin
                                rot_cnt     <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                rot_cnt <= rot_cnt + 1'b1;
                            end
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        // The anode is re-evaluated every cycle, so a digit
                        // cleared in the middle of a slot goes dark on the next edge.
                        anode_n <= lit_value;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    anode_n <= '1;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
module tb_scan_display_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] digit_mask = '0;
    logic [2:0] blink_sel = 3'd1;
    logic       blink_on = 1'b0;
    logic [2:0] select_afisare;
    logic       fetch;
    logic [4:0] anode_n;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [4:0]      mask;
        logic [5:0][2:0] seq;
    } vec_t;

    vec_t tbl [4];

    scan_display_ctrl #(
        .DIGITS(5),
        .PRESCALE(8),
        .BLANK(2),
        .BLINK_SCANS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .digit_mask(digit_mask),
        .blink_sel(blink_sel),
        .blink_on(blink_on),
        .select_afisare(select_afisare),
        .fetch(fetch),
        .anode_n(anode_n)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] lit_of(input logic [2:0] s);
        logic [4:0] a;
        a    = 5'b11111;
        a[s] = 1'b0;
        return a;
    endfunction

    task automatic chk(input string name, input logic ef, input logic [2:0] es,
                       input logic [4:0] ea);
        nvec++;
        if (fetch !== ef || select_afisare !== es || anode_n !== ea) begin
            nerr++;
            $display("FAIL %s: got fetch=%b sel=%0d anode_n=%b, want fetch=%b sel=%0d anode_n=%b",
                     name, fetch, select_afisare, anode_n, ef, es, ea);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // This task starts at the cycle after a fetch edge and stops at the first
    // cycle of the next slot.
    task automatic run_slot(input string name, input logic [2:0] s, input logic [4:0] lit);
        chk({name, "_fetch"}, 1'b1, s, 5'b11111);
        step();
        chk({name, "_dark"}, 1'b0, s, 5'b11111);
        step();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("%s_lit%0d", name, c), 1'b0, s, lit);
            step();
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        blink_on = 1'b0;
        step();
        chk("reset_state", 1'b0, 3'd0, 5'b11111);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0].mask = 5'b11111;
        tbl[0].seq  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        tbl[1].mask = 5'b10010;
        tbl[1].seq  = {3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1};
        tbl[2].mask = 5'b00100;
        tbl[2].seq  = {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        tbl[3].mask = 5'b00011;
        tbl[3].seq  = {3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0};

        for (int t = 0; t < 4; t++) begin
            do_reset();
            digit_mask = tbl[t].mask;
            enable     = 1'b1;
            step();
            for (int s = 0; s < 6; s++) begin
                run_slot($sformatf("tbl%0d_slot%0d", t, s), tbl[t].seq[s], lit_of(tbl[t].seq[s]));
            end
        end

        // enable is dropped during the SHOW of digit 3, then re-enabled with a new mask.
        do_reset();
        digit_mask = 5'b11111;
        enable     = 1'b1;
        step();
        run_slot("drop_s0", 3'd0, lit_of(3'd0));
        run_slot("drop_s1", 3'd1, lit_of(3'd1));
        run_slot("drop_s2", 3'd2, lit_of(3'd2));
        chk("drop_s3_fetch", 1'b1, 3'd3, 5'b11111);
        step();
        chk("drop_s3_dark", 1'b0, 3'd3, 5'b11111);
        step();
        chk("drop_s3_lit0", 1'b0, 3'd3, 5'b10111);
        step();
        chk("drop_s3_lit1", 1'b0, 3'd3, 5'b10111);
        enable = 1'b0;
        step();
        chk("drop_idle", 1'b0, 3'd3, 5'b11111);
        step();
        chk("drop_hold", 1'b0, 3'd3, 5'b11111);
        digit_mask = 5'b10100;
        enable     = 1'b1;
        step();
        run_slot("reenable", 3'd2, 5'b11011);
        run_slot("reen_next", 3'd4, 5'b01111);

        // The current digit's bit is cleared mid-slot. The anode goes dark at
        // once, and the slot still runs its full length.
        do_reset();
        digit_mask = 5'b11111;
        enable     = 1'b1;
        step();
        run_slot("mchg_s0", 3'd0, lit_of(3'd0));
        chk("mchg_fetch", 1'b1, 3'd1, 5'b11111);
        step();
        chk("mchg_dark", 1'b0, 3'd1, 5'b11111);
        step();
        chk("mchg_lit", 1'b0, 3'd1, 5'b11101);
        digit_mask = 5'b11101;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("mchg_off%0d", c), 1'b0, 3'd1, 5'b11111);
            step();
        end
        run_slot("mchg_next", 3'd2, lit_of(3'd2));

        // Setting the mask to zero forces IDLE. A new mask restarts from its lowest bit.
        digit_mask = 5'b00000;
        step();
        chk("mask0_idle", 1'b0, 3'd3, 5'b11111);
        digit_mask = 5'b01010;
        step();
        run_slot("mask0_restart", 3'd1, lit_of(3'd1));

        // reset is pulsed during BLANK.
        do_reset();
        digit_mask = 5'b11111;
        enable     = 1'b1;
        step();
        run_slot("rst_s0", 3'd0, lit_of(3'd0));
        chk("pre_reset", 1'b1, 3'd1, 5'b11111);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 1'b0, 3'd0, 5'b11111);
        step();
        reset = 1'b0;
        step();
        run_slot("post_reset", 3'd0, lit_of(3'd0));

`ifdef SCAN_BLINK_EN
        // With BLINK_SCANS=2, digit 1 goes dark in rotations 2 and 3 only.
        do_reset();
        digit_mask = 5'b11111;
        blink_sel  = 3'd1;
        blink_on   = 1'b1;
        enable     = 1'b1;
        step();
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 5; d++) begin
                run_slot($sformatf("blink_r%0d_d%0d", r, d), 3'(d),
                         (d == 1 && (r == 2 || r == 3)) ? 5'b11111 : lit_of(3'(d)));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
# scan_display_ctrl

Scan scheduler for the multiplexed 7-segment display of the numeric clock. It divides the system clock into per-digit time slots and steps the digit index over the enabled digits only. It inserts an anti-ghosting blanking interval at the start of each slot and drives the active-low anode enables. It also issues a fetch strobe, so the counter/decoder datapath loads the digit selected by `select_afisare` during the blank.

## Interface
Parameters:
- `DIGITS`, default 5: number of display digits, range 1..8.
- `PRESCALE`, default 50000: clock cycles per digit slot, range ≥ 2.
- `BLANK`, default 16: cycles at the start of each slot with all anodes off, range 1..PRESCALE-1.
- `BLINK_SCANS`, default 64: full scan rotations per blink half-period. Used only with `SCAN_BLINK_EN`.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: scanning enabled. When low, the display is dark and the block is held in IDLE.
- `digit_mask` in DIGITS: bit i = 1 shows digit i; 0 skips it.
- `blink_sel` in 3: index of the digit to blink.
- `blink_on` in 1: blink request.
- `select_afisare` out 3: current digit index, fed to the datapath mux.
- `fetch` out 1: one-cycle pulse meaning "load data for the new `select_afisare`".
- `anode_n` out DIGITS: active-low anode enables, at most one bit low.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `select_afisare` = 0.
  - `fetch` = 0.
  - `anode_n` = all ones.
  - Slot counter `cnt` = 0.
  - Blink phase = 0, rotation counter = 0.
- States IDLE, BLANK, SHOW.
- IDLE:
  - Anodes off, `cnt` held at 0.
  - If `enable`=1 and `digit_mask`≠0: `select_afisare` ← lowest set index of `digit_mask`, `fetch` ← 1, go to BLANK.
- BLANK:
  - Anodes off, `cnt` increments.
  - When `cnt`=BLANK-1, go to SHOW.
- SHOW:
  - `anode_n` = ~(onehot(`select_afisare`) & `digit_mask`), minus the blink suppression described below.
  - When `cnt`=PRESCALE-1:
    - `cnt` ← 0.
    - `select_afisare` ← next set index of `digit_mask` strictly after the current one, wrapping DIGITS-1 → 0. If the current index is the only set bit, it is reselected.
    - `fetch` ← 1, go to BLANK.
- Override: `enable`=0 or `digit_mask`=0 in any state sends the block to IDLE on the next edge. `select_afisare` holds its value; anodes turn off on that edge.
- Mid-slot mask change: clearing the bit of the current digit turns its anode off on the next edge. The slot still runs to completion, and the next index is computed from the mask sampled at the slot boundary.
- `fetch` is 0 on every cycle other than the one following an index load.
- A rotation is counted when the next-index computation wraps (new index ≤ old index), including the single-digit reselect case.

## Timing
- Slot length is exactly PRESCALE cycles: BLANK cycles dark, then PRESCALE-BLANK cycles lit.
- Full scan period is PRESCALE × popcount(`digit_mask`) cycles.
- The edge that updates `select_afisare` also raises `fetch` for one cycle; the datapath has BLANK cycles to settle before the anode turns on.
- From IDLE, the first `fetch` appears 1 cycle after `enable` rises, and the first lit anode appears BLANK cycles after that.
- `reset` asserted at any time forces the reset values immediately (asynchronously). After release, normal operation starts from IDLE on the next edge.

## Configuration
- `SCAN_BLINK_EN` defined:
  - A rotation counter toggles the blink phase every BLINK_SCANS rotations.
  - While `blink_on`=1, phase=1 and `select_afisare`=`blink_sel`, the anode stays off for the whole SHOW period.
  - Slot timing, `fetch` and sequencing are unchanged.
- `SCAN_BLINK_EN` undefined: `blink_sel` and `blink_on` are ignored, there is no rotation or phase logic, and behaviour is as if phase is always 0.

## Test plan
Bench parameters: DIGITS=5, PRESCALE=8, BLANK=2.
- Reset, then `enable`=1 with mask 5'b11111 → `select_afisare` sequence 0,1,2,3,4,0. Each `fetch` is followed by 2 dark cycles, then `anode_n`=~onehot for 6 cycles; period is 40 cycles.
- Mask 5'b10010 → sequence 1,4,1,4, with slots of 8 cycles each and no anode low for digits 0, 2 or 3.
- Mask 5'b00100 → `select_afisare` stays 2, `fetch` pulses every 8 cycles, and `anode_n`=5'b11011 during the 6 lit cycles of each slot.
- `enable` dropped during SHOW of digit 3 → next edge gives `anode_n`=5'b11111 and state IDLE with `select_afisare` still 3. Re-enabling yields `fetch` with `select_afisare`=lowest set bit.
- `reset` pulsed mid-BLANK → immediately `anode_n` all ones, `select_afisare`=0, `fetch`=0.
- With `SCAN_BLINK_EN`, BLINK_SCANS=2, `blink_on`=1, `blink_sel`=1 and full mask → digit 1 is lit in rotations 0–1, dark in rotations 2–3, lit again in rotations 4–5, while all other digits are unaffected.
